// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the register-file writeback front end.
package rv_wb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// Long-latency (mul/div) result queue with per-entry kill bits and a
// registered mask of destinations still waiting to be written.
module wb_ll_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [REG_AW-1:0]        push_addr,
  input  logic [REG_DW-1:0]        push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [REG_AW-1:0]        kill_addr,
  output wb_req_t                  head,
  output logic                     head_killed,
  output logic                     ready,
  output logic [(1<<REG_AW)-1:0]   pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  wb_req_t                 ent_q [DEPTH];
  wb_req_t                 ent_n [DEPTH];
  logic [DEPTH-1:0]        kill_q;
  logic [DEPTH-1:0]        kill_n;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_n;
  logic [(1<<REG_AW)-1:0]  pend_n;

  assign head        = ent_q[rd_ptr];
  assign head_killed = kill_q[rd_ptr];
  assign ready       = (count_q != FULL);

  // Kill only looks at entries already resident; a result arriving in the
  // same cycle as the pipeline write is queued live.
  always_comb begin
    ent_n  = ent_q;
    kill_n = kill_q;
    pend_n = '0;
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && ent_q[i].addr == kill_addr) kill_n[i] = 1'b1;
      end
    end
    if (pop) begin
      ent_n[rd_ptr].valid = 1'b0;
      kill_n[rd_ptr]      = 1'b0;
    end
    if (push) begin
      ent_n[wr_ptr] = '{valid: 1'b1, addr: push_addr, data: push_data};
      kill_n[wr_ptr] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_n[i].valid && !kill_n[i] && ent_n[i].addr != REG_ZERO)
        pend_n[ent_n[i].addr] = 1'b1;
    end
  end

  always_comb begin
    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + CNT_ONE;
      2'b01:   count_n = count_q - CNT_ONE;
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      kill_q  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
      kill_q  <= kill_n;
      rd_ptr  <= pop  ? rd_ptr + PTR_ONE : rd_ptr;
      wr_ptr  <= push ? wr_ptr + PTR_ONE : wr_ptr;
      count_q <= count_n;
      pending <= pend_n;
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write port arbiter: pipeline writeback beats queued mul/div
// results. Optional WB_BYPASS_EN adds decode forwarding of the current write.
module reg_writeback_ctrl
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PIPE_VALID,
  input  logic [AW-1:0]     PIPE_ADDR,
  input  logic [DW-1:0]     PIPE_DATA,
  input  logic              LL_VALID,
  output logic              LL_READY,
  input  logic [AW-1:0]     LL_ADDR,
  input  logic [DW-1:0]     LL_DATA,
  output logic              WRITE,
  output logic [AW-1:0]     INADDRESS,
  output logic [DW-1:0]     IN,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0]     BYP_ADDR1,
  input  logic [AW-1:0]     BYP_ADDR2,
  output logic              BYP_HIT1,
  output logic              BYP_HIT2,
  output logic [DW-1:0]     BYP_DATA1,
  output logic [DW-1:0]     BYP_DATA2,
`endif
  output logic [(1<<AW)-1:0] LL_PENDING
);

  wb_req_t head;
  wb_req_t sel;
  logic    head_killed;
  logic    fifo_ready;
  logic    pipe_issue;
  logic    push;
  logic    pop;

  assign pipe_issue = PIPE_VALID && (PIPE_ADDR != REG_ZERO);
  assign LL_READY   = fifo_ready && !RESET;
  assign push       = LL_VALID && LL_READY;

  wb_ll_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (CLK),
    .reset       (RESET),
    .push        (push),
    .push_addr   (LL_ADDR),
    .push_data   (LL_DATA),
    .pop         (pop),
    .kill_en     (pipe_issue),
    .kill_addr   (PIPE_ADDR),
    .head        (head),
    .head_killed (head_killed),
    .ready       (fifo_ready),
    .pending     (LL_PENDING)
  );

  // A pipeline write to x0 leaves the port free, so the FIFO head may drain.
  always_comb begin
    sel = '{valid: 1'b0, addr: INADDRESS, data: IN};
    pop = 1'b0;
    if (pipe_issue) begin
      sel = '{valid: 1'b1, addr: PIPE_ADDR, data: PIPE_DATA};
    end else if (head.valid) begin
      pop = 1'b1;
      if (!head_killed && head.addr != REG_ZERO) sel = head;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
    end else begin
      WRITE     <= sel.valid;
      INADDRESS <= sel.addr;
      IN        <= sel.data;
    end
  end

`ifdef WB_BYPASS_EN
  assign BYP_HIT1  = WRITE && (INADDRESS == BYP_ADDR1) && (BYP_ADDR1 != REG_ZERO);
  assign BYP_HIT2  = WRITE && (INADDRESS == BYP_ADDR2) && (BYP_ADDR2 != REG_ZERO);
  assign BYP_DATA1 = IN;
  assign BYP_DATA2 = IN;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios plus random
// traffic against a queue-based reference model of the writeback rules.
module tb_reg_writeback_ctrl;

  localparam int DEPTH = 2;

  logic        CLK;
  logic        RESET;
  logic        PIPE_VALID;
  logic [4:0]  PIPE_ADDR;
  logic [31:0] PIPE_DATA;
  logic        LL_VALID;
  logic        LL_READY;
  logic [4:0]  LL_ADDR;
  logic [31:0] LL_DATA;
  logic        WRITE;
  logic [4:0]  INADDRESS;
  logic [31:0] IN;
  logic [31:0] LL_PENDING;
`ifdef WB_BYPASS_EN
  logic [4:0]  BYP_ADDR1;
  logic [4:0]  BYP_ADDR2;
  logic        BYP_HIT1;
  logic        BYP_HIT2;
  logic [31:0] BYP_DATA1;
  logic [31:0] BYP_DATA2;
`endif

  reg_writeback_ctrl #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PIPE_VALID (PIPE_VALID),
    .PIPE_ADDR  (PIPE_ADDR),
    .PIPE_DATA  (PIPE_DATA),
    .LL_VALID   (LL_VALID),
    .LL_READY   (LL_READY),
    .LL_ADDR    (LL_ADDR),
    .LL_DATA    (LL_DATA),
    .WRITE      (WRITE),
    .INADDRESS  (INADDRESS),
    .IN         (IN),
`ifdef WB_BYPASS_EN
    .BYP_ADDR1  (BYP_ADDR1),
    .BYP_ADDR2  (BYP_ADDR2),
    .BYP_HIT1   (BYP_HIT1),
    .BYP_HIT2   (BYP_HIT2),
    .BYP_DATA1  (BYP_DATA1),
    .BYP_DATA2  (BYP_DATA2),
`endif
    .LL_PENDING (LL_PENDING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued mul/div results in arrival order, plus the
  // value the write port should show.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          k;
  } ent_t;

  ent_t        q[$];
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          cur_rst;

  logic [70:0] obs_v;
  logic [70:0] exp_v;

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (q[i]) if (!q[i].k && q[i].a != 5'd0) p[q[i].a] = 1'b1;
    return p;
  endfunction

  function automatic bit m_ready();
    return !cur_rst && (q.size() < DEPTH);
  endfunction

  task automatic model_step(input bit rst, input bit pv, input logic [4:0] pa,
                            input logic [31:0] pd, input bit acc,
                            input logic [4:0] la, input logic [31:0] ld);
    ent_t e;
    if (rst) begin
      q.delete();
      m_wr = 0; m_addr = '0; m_data = '0;
      return;
    end
    m_wr = 0;
    if (pv && pa != 5'd0) begin
      m_wr = 1; m_addr = pa; m_data = pd;
      for (int i = 0; i < q.size(); i++) if (q[i].a == pa) q[i].k = 1;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.k && e.a != 5'd0) begin
        m_wr = 1; m_addr = e.a; m_data = e.d;
      end
    end
    if (acc) begin
      e.a = la; e.d = ld; e.k = 0;
      q.push_back(e);
    end
  endtask

  task automatic cycle(input bit rst, input bit pv, input logic [4:0] pa,
                       input logic [31:0] pd, input bit lv, input logic [4:0] la,
                       input logic [31:0] ld, output bit acc);
    RESET = rst; PIPE_VALID = pv; PIPE_ADDR = pa; PIPE_DATA = pd;
    LL_VALID = lv; LL_ADDR = la; LL_DATA = ld;
    cur_rst = rst;
    acc = lv && !rst && (q.size() < DEPTH);
    @(posedge CLK);
    model_step(rst, pv, pa, pd, acc, la, ld);
    #1;
    exp_v = {m_wr, m_addr, m_data, m_pend(), m_ready()};
    obs_v = {WRITE, INADDRESS, IN, LL_PENDING, LL_READY};
  endtask

  task automatic test_reset();
    bit acc;
    for (int c = 0; c < 2; c++) begin
      cycle(1, 0, 0, 0, 1, 5'd3, 32'h1, acc);
      n_tests++;
      if ({WRITE, INADDRESS, IN, LL_PENDING, LL_READY} !== 71'd0) begin
        n_fail++;
        $display("FAIL reset_state: got %h required 0", obs_v);
      end
    end
    cycle(0, 0, 0, 0, 0, 0, 0, acc);
    n_tests++;
    if (LL_READY !== 1'b1 || WRITE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b write=%b required ready=1 write=0", LL_READY, WRITE);
    end
  endtask

  task automatic test_pipe_only();
    bit acc;
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, acc);
    n_tests++;
    if ({WRITE, INADDRESS, IN} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL pipe_only: got %b/%0d/%h required 1/5/deadbeef", WRITE, INADDRESS, IN);
    end
    cycle(0, 0, 0, 32'h12345678, 0, 0, 0, acc);
    n_tests++;
    if ({WRITE, INADDRESS, IN} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL pipe_idle_hold: got %b/%0d/%h required 0/5/deadbeef", WRITE, INADDRESS, IN);
    end
  endtask

  task automatic test_conflict();
    bit          acc;
    bit          pv_s[3] = '{1, 1, 0};
    logic [4:0]  pa_s[3] = '{5'd3, 5'd4, 5'd0};
    bit          lv_s[3] = '{1, 0, 0};
    logic [4:0]  ea[3]   = '{5'd3, 5'd4, 5'd7};
    logic [31:0] ed[3]   = '{32'h33, 32'h44, 32'h11};
    for (int k = 0; k < 3; k++) begin
      cycle(0, pv_s[k], pa_s[k], ed[k], lv_s[k], 5'd7, 32'h11, acc);
      n_tests++;
      if ({WRITE, INADDRESS, IN, LL_PENDING[7]} !== {1'b1, ea[k], ed[k], (k < 2)}) begin
        n_fail++;
        $display("FAIL conflict_%0d: got %b/%0d/%h pend7=%b required 1/%0d/%h pend7=%b",
                 k, WRITE, INADDRESS, IN, LL_PENDING[7], ea[k], ed[k], (k < 2));
      end
    end
    cycle(0, 0, 0, 0, 0, 0, 0, acc);
    n_tests++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL conflict_idle: got %h required %h", obs_v, exp_v);
    end
  endtask

  task automatic test_full();
    bit         acc;
    int         li = 0;
    logic [4:0] ll_a[3] = '{5'd8, 5'd9, 5'd11};
    logic [4:0] got[$];
    for (int k = 0; k < 9; k++) begin
      cycle(0, (k < 5), 5'(k + 1), 32'h200 + k, (li < 3), ll_a[li % 3],
            32'h100 + ll_a[li % 3], acc);
      if (acc) li++;
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL full_model_%0d: got %h required %h", k, obs_v, exp_v);
      end
      if (k >= 1 && k <= 4) begin
        n_tests++;
        if (LL_READY !== 1'b0) begin
          n_fail++;
          $display("FAIL full_ready_%0d: got %b required 0", k, LL_READY);
        end
      end
      if (k >= 5 && WRITE === 1'b1) got.push_back(INADDRESS);
    end
    n_tests++;
    if (got.size() != 3 || got[0] !== 5'd8 || got[1] !== 5'd9 || got[2] !== 5'd11) begin
      n_fail++;
      $display("FAIL full_drain_order: got %0d writes %p required 8,9,11", got.size(), got);
    end
  endtask

  task automatic test_waw_kill();
    bit acc;
    cycle(0, 1, 5'd2, 32'h2, 1, 5'd10, 32'hAA, acc);
    n_tests++;
    if (LL_PENDING[10] !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_pending_set: got %b required 1", LL_PENDING[10]);
    end
    cycle(0, 1, 5'd10, 32'hBB, 0, 0, 0, acc);
    n_tests++;
    if ({WRITE, INADDRESS, IN, LL_PENDING[10]} !== {1'b1, 5'd10, 32'hBB, 1'b0}) begin
      n_fail++;
      $display("FAIL waw_pipe_write: got %b/%0d/%h pend10=%b required 1/10/bb pend10=0",
               WRITE, INADDRESS, IN, LL_PENDING[10]);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, acc);
      n_tests++;
      if ({WRITE, IN} !== {1'b0, 32'hBB}) begin
        n_fail++;
        $display("FAIL waw_no_stale_%0d: got write=%b in=%h required write=0 in=bb", k, WRITE, IN);
      end
    end
  endtask

  task automatic test_x0();
    bit acc;
    cycle(0, 1, 5'd1, 32'h1, 1, 5'd6, 32'h66, acc);
`ifdef WB_BYPASS_EN
    BYP_ADDR1 = 5'd6;
    BYP_ADDR2 = 5'd0;
`endif
    cycle(0, 1, 5'd0, 32'hFFFF, 0, 0, 0, acc);
    n_tests++;
    if ({WRITE, INADDRESS, IN} !== {1'b1, 5'd6, 32'h66}) begin
      n_fail++;
      $display("FAIL x0_drain: got %b/%0d/%h required 1/6/66", WRITE, INADDRESS, IN);
    end
`ifdef WB_BYPASS_EN
    n_tests++;
    if ({BYP_HIT1, BYP_DATA1, BYP_HIT2} !== {1'b1, 32'h66, 1'b0}) begin
      n_fail++;
      $display("FAIL x0_bypass: got hit1=%b data1=%h hit2=%b required 1/66/0",
               BYP_HIT1, BYP_DATA1, BYP_HIT2);
    end
`endif
    cycle(0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h77, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, acc);
    n_tests++;
    if (WRITE !== 1'b0 || LL_PENDING !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_ll_suppress: got write=%b pend=%h required write=0 pend=0", WRITE, LL_PENDING);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    cycle(0, 1, 5'd1, 32'h1, 1, 5'd12, 32'hC12, acc);
    cycle(0, 1, 5'd2, 32'h2, 1, 5'd13, 32'hC13, acc);
    n_tests++;
    if (LL_PENDING !== 32'h3000) begin
      n_fail++;
      $display("FAIL rst_mid_queued: got pend=%h required 3000", LL_PENDING);
    end
    cycle(1, 0, 0, 0, 0, 0, 0, acc);
    n_tests++;
    if ({WRITE, LL_PENDING, LL_READY} !== 34'd0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got write=%b pend=%h ready=%b required 0/0/0",
               WRITE, LL_PENDING, LL_READY);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, acc);
      n_tests++;
      if ({WRITE, LL_READY} !== 2'b01) begin
        n_fail++;
        $display("FAIL rst_mid_after_%0d: got write=%b ready=%b required 0/1", k, WRITE, LL_READY);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    bit rst;
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      cycle(rst, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 15)), $urandom, acc);
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: got %h required %h", k, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; PIPE_VALID = 0; PIPE_ADDR = '0; PIPE_DATA = '0;
    LL_VALID = 0; LL_ADDR = '0; LL_DATA = '0;
`ifdef WB_BYPASS_EN
    BYP_ADDR1 = '0; BYP_ADDR2 = '0;
`endif
    test_reset();
    test_pipe_only();
    test_conflict();
    test_full();
    test_waw_kill();
    test_x0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-side front end for the 32x32 register file.
- Merges the single-cycle pipeline writeback stream with results from the multi-cycle M-extension (mul/div) unit.
- Buffers long-latency results in a small FIFO and drives the register file's single write port (IN/INADDRESS/WRITE) with one registered write per cycle.
- Publishes a pending-destination scoreboard to the hazard unit.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, 2..8)
- AW, 5, register address width
- DW, 32, data width

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- PIPE_VALID  in  1  pipeline writeback valid this cycle (never back-pressured)
- PIPE_ADDR  in  5  pipeline destination register
- PIPE_DATA  in  32  pipeline result
- LL_VALID  in  1  mul/div result valid
- LL_READY  out  1  FIFO can accept; transfer when LL_VALID & LL_READY at posedge
- LL_ADDR  in  5  mul/div destination register
- LL_DATA  in  32  mul/div result
- WRITE  out  1  register file write enable
- INADDRESS  out  5  register file write address
- IN  out  32  register file write data
- LL_PENDING  out  32  bit i set = a FIFO entry targets register i

Behaviour:
- Reset: on posedge with RESET=1, FIFO emptied, all entries invalidated, WRITE=0, INADDRESS=0, IN=0, LL_PENDING=0.
  - LL_READY=0 while RESET=1; LL_READY=1 in the first cycle after RESET drops.
  - Reset mid-operation discards queued results without writing them.
- Output stage: WRITE/INADDRESS/IN are registered. A source selected in cycle N appears on the write port in cycle N+1.
- Per-cycle arbitration:
  - PIPE_VALID & PIPE_ADDR!=0 → pipeline write issued. Pipeline always wins.
  - Otherwise, if FIFO head valid and not killed → head written and popped.
  - Otherwise, if head killed → head popped with no write; WRITE=0 that cycle.
  - Otherwise → WRITE=0; INADDRESS/IN hold their previous values.
- x0 rule: any write with address 0, from either source, is suppressed (WRITE=0). A pipeline write to x0 does not consume the port, so the FIFO head may drain in that cycle.
  - LL results to x0 are still accepted, then popped without writing.
- WAW kill: when a pipeline write to address A is issued, every valid FIFO entry with address A is marked killed in the same posedge. The younger pipeline value must not be overwritten by an older mul/div result.
  - Killed entries are still popped in order and clear their LL_PENDING bit.
- LL_READY = (count < DEPTH), from registered count only. No combinational path from LL_VALID.
  - At full, no push occurs even if a pop happens that cycle.
  - Push and pop in the same cycle when not full leaves count unchanged.
- LL_PENDING: OR over valid, non-killed entries of decode(addr), excluding x0. Registered; updates the cycle after push, kill, or pop.
- Pointers wrap modulo DEPTH; count is 0..DEPTH inclusive.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined: adds inputs BYP_ADDR1, BYP_ADDR2 (5 bits each) and outputs BYP_HIT1, BYP_HIT2 (1 bit), BYP_DATA1, BYP_DATA2 (32 bits).
  - BYP_HITk = WRITE & (INADDRESS == BYP_ADDRk) & (BYP_ADDRk != 0); BYP_DATAk = IN.
  - Combinational. Lets decode forward the value being written this cycle.
- Undefined: these ports are absent; the consumer waits one cycle.

Decomposition:
- Shared package rv_wb_pkg: constants REG_AW=5, REG_DW=32, REG_ZERO=5'd0; typedef wb_req_t {valid, addr, data}.
- One natural sub-module: wb_ll_fifo. Holds the circular buffer with per-entry valid/killed bits, the kill-by-address port, and the pending-mask generation. Arbitration and the output register stay in the top.

Test Plan:
- Reset mid-run: 2 LL entries queued, assert RESET one cycle → WRITE=0, LL_PENDING=0, LL_READY=0 during reset, 1 next cycle; no queued write ever appears.
- Pipe only: PIPE x5=0xDEADBEEF at cycle N → WRITE=1, INADDRESS=5, IN=0xDEADBEEF at N+1.
- Conflict: LL x7=0x11 accepted while PIPE writes x3, x4 back-to-back → x3, x4, then x7=0x11 on consecutive cycles; LL_PENDING bit7 set until x7 is written.
- Full FIFO: push x8, x9 with PIPE continuously busy → LL_READY=0; a third LL_VALID holds until PIPE idles; drain order x8, x9, then the third.
- WAW kill: LL x10=0xAA queued, PIPE writes x10=0xBB → only 0xBB is written to x10; LL_PENDING bit10 clears; an idle write-port cycle occurs at the pop.
- x0: PIPE x0 concurrent with queued LL x6 → WRITE for x6 next cycle, no x0 write. With WB_BYPASS_EN: BYP_ADDR1=6 during that write → BYP_HIT1=1, BYP_DATA1 = x6 data.
